// File: rtl/sha3_theta_pipe_pkg.sv
// Shared Keccak types and helpers for the theta stage.
// Lanes are carried at the widest legal width and narrowed inside each module.
package sha3_pkg;

  localparam int KECCAK_ROWS = 5;
  localparam int KECCAK_COLS = 5;
  localparam int LANE_W_MAX  = 64;

  // lane_t is sized for Keccak-f[1600]; narrower instances use the low LANE_W bits
  typedef logic [LANE_W_MAX-1:0] lane_t;
  typedef lane_t [KECCAK_COLS-1:0] row_t;

  // Rotate left by one within the low w bits; bits at and above w are cleared
  function automatic lane_t rotl1(input lane_t v, input int w);
    lane_t r;
    r = {v[LANE_W_MAX-2:0], 1'b0};
    r[0] = v[6'(w - 1)];
    for (int i = 0; i < LANE_W_MAX; i++) begin
      if (i >= w) r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [2:0] col_prev(input int x);
    return 3'((x + KECCAK_COLS - 1) % KECCAK_COLS);
  endfunction

  function automatic logic [2:0] col_next(input int x);
    return 3'((x + 1) % KECCAK_COLS);
  endfunction

endpackage

// File: rtl/sha3_theta_pipe_if.sv
// State-in / state-out bundle for the theta pipeline with valid and stall.
// Row vectors are indexed [x], so row y lane x is A[x][y].
interface sha3_theta_pipe_if
  import sha3_pkg::*;
#(
  parameter int LANE_W = 64
);
  logic [KECCAK_COLS-1:0][LANE_W-1:0] isa, isb, isc, isd, ise;
  logic [KECCAK_COLS-1:0][LANE_W-1:0] osa, osb, osc, osd, ose;
  logic sample;
  logic stall;
  logic good;
  logic busy;

  modport master (
    output isa, isb, isc, isd, ise, sample, stall,
    input  osa, osb, osc, osd, ose, good, busy
  );

  modport slave (
    input  isa, isb, isc, isd, ise, sample, stall,
    output osa, osb, osc, osd, ose, good, busy
  );
endinterface

// File: rtl/sha3_theta_pipe_parity.sv
// Column parity C[x] of a 5x5 Keccak state: XOR of the five lanes in column x.
module sha3_theta_parity
  import sha3_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [KECCAK_COLS-1:0][LANE_W-1:0] row0,
  input  logic [KECCAK_COLS-1:0][LANE_W-1:0] row1,
  input  logic [KECCAK_COLS-1:0][LANE_W-1:0] row2,
  input  logic [KECCAK_COLS-1:0][LANE_W-1:0] row3,
  input  logic [KECCAK_COLS-1:0][LANE_W-1:0] row4,
  output logic [KECCAK_COLS-1:0][LANE_W-1:0] parity
);

  always_comb begin
    parity = '0;
    for (int x = 0; x < KECCAK_COLS; x++) begin
      parity[x] = row0[x] ^ row1[x] ^ row2[x] ^ row3[x] ^ row4[x];
    end
  end

endmodule

// File: rtl/sha3_theta_pipe.sv
// Keccak-f theta step with one or two register stages and a global stall.
// Output lanes hold their last value while idle; only rst clears them.
module sha3_theta_pipe
  import sha3_pkg::*;
#(
  parameter int    LANE_W             = 64,
  parameter int    PIPE_STAGES        = 1,
  parameter string BINARY_LOGIC_STYLE = "basic"
) (
  input logic              clk,
  input logic              rst,
  sha3_theta_pipe_if.slave bus
);

  typedef logic [LANE_W-1:0]              lane_w_t;
  typedef lane_w_t [KECCAK_COLS-1:0]      plane_t;
  typedef plane_t  [KECCAK_ROWS-1:0]      state_t;

  generate
    if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane
      $error("sha3_theta_pipe: LANE_W must be 8, 16, 32 or 64");
    end
    if (!(PIPE_STAGES == 1 || PIPE_STAGES == 2)) begin : g_bad_stages
      $error("sha3_theta_pipe: PIPE_STAGES must be 1 or 2");
    end
    if (BINARY_LOGIC_STYLE != "basic") begin : g_bad_style
      $error("sha3_theta_pipe: only the basic XOR tree style is implemented");
    end
  endgenerate

  // D[x] = C[x-1] ^ rotl(C[x+1], 1)
  function automatic plane_t theta_d(input plane_t c);
    plane_t d;
    for (int x = 0; x < KECCAK_COLS; x++) begin
      d[x] = c[col_prev(x)] ^ lane_w_t'(rotl1(lane_t'(c[col_next(x)]), LANE_W));
    end
    return d;
  endfunction

  function automatic state_t theta_apply(input state_t a, input plane_t d);
    state_t r;
    for (int y = 0; y < KECCAK_ROWS; y++) begin
      for (int x = 0; x < KECCAK_COLS; x++) begin
        r[y][x] = a[y][x] ^ d[x];
      end
    end
    return r;
  endfunction

  state_t in_state;
  state_t out_state;
  plane_t c_in;
  logic   good_int;
  logic   busy_int;

  always_comb begin
    in_state    = '0;
    in_state[0] = bus.isa;
    in_state[1] = bus.isb;
    in_state[2] = bus.isc;
    in_state[3] = bus.isd;
    in_state[4] = bus.ise;
  end

  sha3_theta_parity #(
    .LANE_W (LANE_W)
  ) u_parity (
    .row0   (bus.isa),
    .row1   (bus.isb),
    .row2   (bus.isc),
    .row3   (bus.isd),
    .row4   (bus.ise),
    .parity (c_in)
  );

  generate
    if (PIPE_STAGES == 1) begin : g_one
      logic   vld_p0;
      state_t out_p0;

      // stage p0: full theta result
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p0 <= 1'b0;
          out_p0 <= '0;
        end else if (!bus.stall) begin
          vld_p0 <= bus.sample;
          if (bus.sample) out_p0 <= theta_apply(in_state, theta_d(c_in));
        end
      end

      assign out_state = out_p0;
      assign good_int  = vld_p0;
      assign busy_int  = vld_p0;
    end else begin : g_two
      logic   vld_p0;
      state_t a_p0;
      plane_t c_p0;
      logic   vld_p1;
      state_t out_p1;

      // stage p0: raw state plus column parities
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p0 <= 1'b0;
          a_p0   <= '0;
          c_p0   <= '0;
        end else if (!bus.stall) begin
          vld_p0 <= bus.sample;
          if (bus.sample) begin
            a_p0 <= in_state;
            c_p0 <= c_in;
          end
        end
      end

      // stage p1: D mix and final XOR
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1 <= 1'b0;
          out_p1 <= '0;
        end else if (!bus.stall) begin
          vld_p1 <= vld_p0;
          if (vld_p0) out_p1 <= theta_apply(a_p0, theta_d(c_p0));
        end
      end

      assign out_state = out_p1;
      assign good_int  = vld_p1;
      assign busy_int  = vld_p0 | vld_p1;
    end
  endgenerate

  assign bus.osa  = out_state[0];
  assign bus.osb  = out_state[1];
  assign bus.osc  = out_state[2];
  assign bus.osd  = out_state[3];
  assign bus.ose  = out_state[4];
  assign bus.good = good_int;
  assign bus.busy = busy_int;

endmodule

// File: tb/tb_sha3_theta_pipe.sv
// Directed bench for sha3_theta_pipe: 64-bit single stage, 64-bit two stage,
// and 8-bit single stage instances sharing one clock and reset.
module tb_sha3_theta_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha3_theta_pipe_if #(.LANE_W(64)) bus1 ();
  sha3_theta_pipe_if #(.LANE_W(64)) bus2 ();
  sha3_theta_pipe_if #(.LANE_W(8))  bus3 ();

  sha3_theta_pipe #(.LANE_W(64), .PIPE_STAGES(1), .BINARY_LOGIC_STYLE("basic")) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));
  sha3_theta_pipe #(.LANE_W(64), .PIPE_STAGES(2), .BINARY_LOGIC_STYLE("basic")) dut2 (
    .clk (clk), .rst (rst), .bus (bus2));
  sha3_theta_pipe #(.LANE_W(8), .PIPE_STAGES(1), .BINARY_LOGIC_STYLE("basic")) dut3 (
    .clk (clk), .rst (rst), .bus (bus3));

  int n_assert = 0;
  int n_fail   = 0;

  typedef logic [63:0] st_t [5][5];  // [x][y]

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic st_t zero_st();
    st_t z;
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) z[x][y] = 64'd0;
    return z;
  endfunction

  function automatic st_t rand_st();
    st_t z;
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) z[x][y] = {$urandom, $urandom};
    return z;
  endfunction

  // Reference theta for 64-bit lanes
  function automatic st_t theta_model(input st_t a);
    logic [63:0] c [5];
    logic [63:0] d [5];
    logic [63:0] cn;
    st_t r;
    for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
    for (int x = 0; x < 5; x++) begin
      cn   = c[(x + 1) % 5];
      d[x] = c[(x + 4) % 5] ^ {cn[62:0], cn[63]};
    end
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) r[x][y] = a[x][y] ^ d[x];
    return r;
  endfunction

  task automatic drive1(input st_t a, input logic s);
    for (int x = 0; x < 5; x++) begin
      bus1.isa[x] = a[x][0]; bus1.isb[x] = a[x][1]; bus1.isc[x] = a[x][2];
      bus1.isd[x] = a[x][3]; bus1.ise[x] = a[x][4];
    end
    bus1.sample = s;
  endtask

  task automatic drive2(input st_t a, input logic s);
    for (int x = 0; x < 5; x++) begin
      bus2.isa[x] = a[x][0]; bus2.isb[x] = a[x][1]; bus2.isc[x] = a[x][2];
      bus2.isd[x] = a[x][3]; bus2.ise[x] = a[x][4];
    end
    bus2.sample = s;
  endtask

  function automatic logic [63:0] out1(input int x, input int y);
    logic [2:0] i;
    i = x[2:0];
    case (y)
      0: return bus1.osa[i];
      1: return bus1.osb[i];
      2: return bus1.osc[i];
      3: return bus1.osd[i];
      default: return bus1.ose[i];
    endcase
  endfunction

  function automatic logic [63:0] out2(input int x, input int y);
    logic [2:0] i;
    i = x[2:0];
    case (y)
      0: return bus2.osa[i];
      1: return bus2.osb[i];
      2: return bus2.osc[i];
      3: return bus2.osd[i];
      default: return bus2.ose[i];
    endcase
  endfunction

  function automatic logic [63:0] out3(input int x, input int y);
    logic [2:0] i;
    i = x[2:0];
    case (y)
      0: return 64'(bus3.osa[i]);
      1: return 64'(bus3.osb[i]);
      2: return 64'(bus3.osc[i]);
      3: return 64'(bus3.osd[i]);
      default: return 64'(bus3.ose[i]);
    endcase
  endfunction

  task automatic check_out1(input string tag, input st_t e);
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++)
      check($sformatf("%s_A[%0d][%0d]", tag, x, y), out1(x, y), e[x][y]);
  endtask

  task automatic check_out2(input string tag, input st_t e);
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++)
      check($sformatf("%s_A[%0d][%0d]", tag, x, y), out2(x, y), e[x][y]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    st_t a, e, s0, s1, s2, s3, s4, s5;

    rst = 1'b1;
    drive1(zero_st(), 1'b0);
    drive2(zero_st(), 1'b0);
    bus1.stall = 1'b0;
    bus2.stall = 1'b0;
    bus3.stall = 1'b0;
    bus3.sample = 1'b0;
    bus3.isa = '0; bus3.isb = '0; bus3.isc = '0; bus3.isd = '0; bus3.ise = '0;
    tick();
    tick();

    // reset state
    check("rst_good1", 64'(bus1.good), 64'd0);
    check("rst_busy1", 64'(bus1.busy), 64'd0);
    check("rst_good2", 64'(bus2.good), 64'd0);
    check("rst_busy2", 64'(bus2.busy), 64'd0);
    check("rst_good3", 64'(bus3.good), 64'd0);
    check_out1("rst_out1", zero_st());
    rst = 1'b0;
    tick();

    // 1: all-zero state, latency 1
    drive1(zero_st(), 1'b1);
    tick();
    check("t1_good", 64'(bus1.good), 64'd1);
    check("t1_busy", 64'(bus1.busy), 64'd1);
    check_out1("t1", zero_st());
    drive1(zero_st(), 1'b0);
    tick();
    check("t1_good_drop", 64'(bus1.good), 64'd0);
    check("t1_busy_drop", 64'(bus1.busy), 64'd0);

    // 2: single bit at A[0][0]
    a = zero_st();
    a[0][0] = 64'h1;
    drive1(a, 1'b1);
    tick();
    e = zero_st();
    for (int y = 0; y < 5; y++) begin
      e[1][y] = 64'h1;
      e[4][y] = 64'h2;
    end
    e[0][0] = 64'h1;
    check("t2_good", 64'(bus1.good), 64'd1);
    check_out1("t2", e);

    // 3: rotation wrap, issued back-to-back with test 2
    a[0][0] = 64'h8000_0000_0000_0000;
    drive1(a, 1'b1);
    tick();
    e = zero_st();
    for (int y = 0; y < 5; y++) begin
      e[1][y] = 64'h8000_0000_0000_0000;
      e[4][y] = 64'h1;
    end
    e[0][0] = 64'h8000_0000_0000_0000;
    check("t3_good", 64'(bus1.good), 64'd1);
    check_out1("t3", e);
    drive1(zero_st(), 1'b0);
    tick();
    check("t3_idle_good", 64'(bus1.good), 64'd0);
    check_out1("t3_hold", e);

    // 5: 8-bit lanes, A[2][3] = 0x80
    bus3.isd[2] = 8'h80;
    bus3.sample = 1'b1;
    tick();
    bus3.sample = 1'b0;
    bus3.isd[2] = 8'h00;
    check("t5_good", 64'(bus3.good), 64'd1);
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        logic [63:0] ev;
        ev = (x == 3) ? 64'h80 : (x == 1) ? 64'h01 : 64'h00;
        if (x == 2 && y == 3) ev = 64'h80;
        check($sformatf("t5_A[%0d][%0d]", x, y), out3(x, y), ev);
      end
    end

    // 4: two-stage pipe, back-to-back samples with a 3-cycle stall
    s0 = rand_st();
    s1 = rand_st();
    s2 = rand_st();
    drive2(s0, 1'b1);
    tick();
    check("t4_lat_good", 64'(bus2.good), 64'd0);
    check("t4_lat_busy", 64'(bus2.busy), 64'd1);
    drive2(s1, 1'b1);
    tick();
    check("t4_s0_good", 64'(bus2.good), 64'd1);
    check_out2("t4_s0", theta_model(s0));
    drive2(s2, 1'b1);
    bus2.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t4_stall%0d_good", k), 64'(bus2.good), 64'd1);
      check($sformatf("t4_stall%0d_busy", k), 64'(bus2.busy), 64'd1);
      check_out2($sformatf("t4_stall%0d", k), theta_model(s0));
    end
    bus2.stall = 1'b0;
    tick();
    check("t4_s1_good", 64'(bus2.good), 64'd1);
    check_out2("t4_s1", theta_model(s1));
    drive2(zero_st(), 1'b0);
    tick();
    check("t4_s2_good", 64'(bus2.good), 64'd1);
    check_out2("t4_s2", theta_model(s2));
    tick();
    check("t4_end_good", 64'(bus2.good), 64'd0);
    check("t4_end_busy", 64'(bus2.busy), 64'd0);
    check_out2("t4_hold", theta_model(s2));

    // 6: asynchronous reset with two states in flight
    s3 = rand_st();
    s4 = rand_st();
    s5 = rand_st();
    drive2(s3, 1'b1);
    tick();
    drive2(s4, 1'b1);
    tick();
    check("t6_pre_good", 64'(bus2.good), 64'd1);
    check("t6_pre_busy", 64'(bus2.busy), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_good", 64'(bus2.good), 64'd0);
    check("t6_rst_busy", 64'(bus2.busy), 64'd0);
    check_out2("t6_rst", zero_st());
    drive2(zero_st(), 1'b0);
    tick();
    rst = 1'b0;
    drive2(s5, 1'b1);
    tick();
    drive2(zero_st(), 1'b0);
    check("t6_lat_good", 64'(bus2.good), 64'd0);
    check("t6_lat_busy", 64'(bus2.busy), 64'd1);
    tick();
    check("t6_s5_good", 64'(bus2.good), 64'd1);
    check_out2("t6_s5", theta_model(s5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_theta_pipe.md
Name: sha3_theta_pipe

Overview:
- Parametrised Keccak-f theta step.
- Computes column parities and applies the theta XOR to a full 5x5 state of LANE_W-bit lanes.
- Optional second register stage, plus a stall input so the block can sit in a round pipeline with back-pressure.
- Sits between state absorb/previous round output and the rho/pi stage; replaces the pass-through theta stub.

Parameters:
- LANE_W, 64, lane width in bits; legal values 8, 16, 32, 64 (Keccak-f[200..1600]); any other value is an elaboration error.
- PIPE_STAGES, 1, register stages from sample to good; legal values 1 or 2.
- BINARY_LOGIC_STYLE, "basic", XOR tree implementation selector; "basic" is the only value required now.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- isa, isb, isc, isd, ise  in  5 x LANE_W each  state rows y=0..4; index [x] is column x, so lane A[x][y].
- sample  in  1  input state valid this cycle.
- stall  in  1  downstream not ready; freezes the whole pipeline.
- osa, osb, osc, osd, ose  out  5 x LANE_W each  theta output rows y=0..4, same indexing.
- good  out  1  output state valid.
- busy  out  1  high while any pipeline stage holds valid data.

Behaviour:
- Reset (one clock, asynchronous, active-high): all state and valid registers clear immediately on rst assertion. All out lanes = 0, good = 0, busy = 0. Release is synchronous to clk.
- Function, with x±1 taken mod 5 and rotl by 1 taken mod LANE_W:
  - C[x] = A[x][0]^A[x][1]^A[x][2]^A[x][3]^A[x][4].
  - D[x] = C[x-1] ^ rotl(C[x+1], 1).
  - A'[x][y] = A[x][y] ^ D[x].
- PIPE_STAGES=1:
  - Single register stage holding A'.
  - Latency 1: sample at edge N gives good and the result after edge N.
- PIPE_STAGES=2:
  - Stage 1 registers the input state A and C[0..4].
  - Stage 2 registers A'.
  - Latency 2.
- Valid flow: each stage has a valid bit. Stage 1 valid loads sample; stage k valid loads stage k-1 valid.
- stall=1: no register (data or valid) changes. sample is ignored and its data is dropped; the producer must hold sample and data until stall falls. Outputs and good hold their values.
- stall=0: the pipeline advances every cycle, so throughput is one state per cycle. Back-to-back samples produce back-to-back good.
- good = last-stage valid. Out lanes hold the last computed value when good=0 (not cleared).
- busy = OR of all stage valid bits.
- Data registers load only when the stage valid-in is 1 and stall=0. This is a power measure; outputs remain stable while idle.
- sample and stall both high in the same cycle: stall wins, and the input is not captured.
- rst mid-operation: all in-flight states are discarded; good = 0 on the next cycle regardless of stall.

Decomposition:
- Package sha3_pkg:
  - typedef lane_t (parametrised via LANE_W).
  - typedef row_t = lane_t[5].
  - localparam KECCAK_ROWS=5 and KECCAK_COLS=5.
  - function rotl1.
- Sub-module sha3_theta_parity: combinational five-input XOR tree producing C[0..4] from the state, shared by both PIPE_STAGES variants.

Test Plan:
1. Reset, then sample an all-zero state (LANE_W=64, PIPE_STAGES=1) → good high exactly 1 cycle later; all 25 output lanes = 0; busy=1 for one cycle.
2. A[0][0]=64'h1, all other lanes 0 → A'[0][0]=1; column 1 lanes all = 64'h1; column 4 lanes all = 64'h2; columns 2 and 3 all 0.
3. Rotation wrap: A[0][0]=64'h8000_0000_0000_0000 → column 4 lanes = 64'h1; column 1 lanes = 64'h8000_0000_0000_0000; A'[0][0] unchanged.
4. PIPE_STAGES=2, three back-to-back samples with random states; stall pulsed high for 3 cycles mid-stream → outputs match the software theta model in order, no loss or duplication; good latency = 2 plus stall cycles; outputs frozen during the stall.
5. LANE_W=8, A[2][3]=8'h80 → column 3 lanes = 8'h80; column 1 lanes = 8'h01 (rotate wraps at bit 7).
6. Assert rst asynchronously between clk edges while two states are in flight (PIPE_STAGES=2) → good and busy fall immediately, outputs read 0; after release, a new sample produces a correct result at latency 2.
